// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate generator for the decode stage. It accepts instr[31:7]
// plus a 3-bit format select, decodes the immediate when the item is captured,
// and presents an XLEN-wide extended immediate one cycle later.
//
// Both sides use a valid/ready handshake. Storage is an output register (OUT)
// plus a skid register (SKID). Because in_ready depends only on the skid
// state, fetch never sees a combinational path from out_ready.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   in_valid     in   1      upstream item valid
//   in_ready     out  1      block can accept an item this cycle
//   in_instr     in   25     instr[31:7]
//   in_immsrc    in   3      format select (I,S,B,J,U,Z,SH,illegal)
//   in_tag       in   TAG_W  side-band tag, passed through unchanged
//   out_valid    out  1      output item valid
//   out_ready    in   1      downstream accepts the output item
//   out_imm      out  XLEN   extended immediate
//   out_tag      out  TAG_W  tag of the output item
//   out_illegal  out  1      format select was 3'b111
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    // Reject unsupported configurations at elaboration time.
    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("imm_extend_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // The argument is instr[31:7], so instr[k] is ins[k-7].
    // A 32-bit value is built first. It is then sign- or zero-extended to XLEN.
    function automatic logic [XLEN-1:0] decode_imm(input logic [24:0] ins,
                                                   input logic [2:0]  src);
        logic [31:0] v;
        logic        sx;
        logic        s;
        s  = ins[24];
        v  = 32'd0;
        sx = 1'b1;
        case (src)
            3'b000: v = {{20{s}}, ins[24:13]};
            3'b001: v = {{20{s}}, ins[24:18], ins[4:0]};
            3'b010: v = {{19{s}}, s, ins[0], ins[23:18], ins[4:1], 1'b0};
            3'b011: v = {{11{s}}, s, ins[12:5], ins[13], ins[23:14], 1'b0};
            3'b100: v = {ins[24:5], 12'd0};
            3'b101: begin
                v  = {27'd0, ins[12:8]};
                sx = 1'b0;
            end
            3'b110: begin
                // A 64-bit shift amount needs the extra bit instr[25].
                v  = (XLEN == 64) ? {26'd0, ins[18:13]} : {27'd0, ins[17:13]};
                sx = 1'b0;
            end
            default: begin
                v  = 32'd0;
                sx = 1'b0;
            end
        endcase
        decode_imm = sx ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_ill_s;
    logic             accept_s;
    logic             out_free_s;

    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic             out_illegal_q, out_illegal_d;
    logic             skid_valid_q,  skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;
    logic             skid_illegal_q, skid_illegal_d;

    assign in_ready    = !reset && !skid_valid_q;
    assign accept_s    = in_valid && in_ready;
    assign out_free_s  = !out_valid_q || out_ready;

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

    // Decode the incoming instruction so that OUT or SKID can capture it.
    always_comb begin
        dec_imm_s = decode_imm(in_instr, in_immsrc);
        dec_ill_s = (in_immsrc == 3'b111);
    end

    // Compute the next state of OUT and SKID from the handshake.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;

        if (skid_valid_q) begin
            // in_ready is low, so no new item can arrive. Only drain SKID.
            if (out_free_s) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_tag_d     = skid_tag_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = 1'b0;
            end else begin
                skid_valid_d  = 1'b1;
            end
        end else if (accept_s) begin
            if (out_free_s) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm_s;
                out_tag_d     = in_tag;
                out_illegal_d = dec_ill_s;
            end else begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm_s;
                skid_tag_d     = in_tag;
                skid_illegal_d = dec_ill_s;
            end
        end else begin
            if (out_free_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // OUT and SKID storage. Reset discards any item in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

endmodule
